imem_responder: RTL and testbench

- Instruction-memory responder that serves read requests issued by the fetch stage over a valid/ready request and valid/ready response handshake.
- The latency is programmable, so fetch must stall on a real multi-cycle memory instead of relying on a single-cycle array.
- Sits between the fetch stage (initiator) and the word-organised instruction store.
- Includes a preload write port for the loader/bench, and a flush input so a taken branch can cancel an in-flight fetch.

---
 rtl/imem_responder_if.sv | 26 ++
 rtl/imem_responder.sv | 108 ++++++++++
 tb/tb_imem_responder.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_responder_if.sv
// Fetch-side bus of the instruction-memory responder: request/response
// handshakes, branch flush and the preload write port.
interface imem_responder_if;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [15:0] rsp_addr;
  logic        rsp_err;
  logic        flush;
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [15:0] ld_data;

  modport master (
    output req_valid, req_addr, rsp_ready, flush, ld_en, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, flush, ld_en, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );
endinterface

// File: rtl/imem_responder.sv
// Single-outstanding instruction-memory responder with programmable latency,
// flush cancel and a preload write port.
module imem_responder #(
  parameter int DEPTH_LOG2 = 15,
  parameter int LATENCY    = 4
) (
  input  logic            clk,
  input  logic            rst,
  imem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic [15:0] r_addr;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_data;
  logic [15:0] r_rsp_addr;
  logic        r_rsp_err;
  logic [15:0] mem [0:(2**DEPTH_LOG2)-1];

  logic                  w_accept;
  logic                  w_enter_resp;
  logic [15:0]           w_rd_addr;
  logic [DEPTH_LOG2-1:0] w_rd_idx;
  logic [DEPTH_LOG2-1:0] w_ld_idx;
  logic                  w_unused_ld;

  assign bus.req_ready = (r_state == IDLE) & ~rst;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_addr  = r_rsp_addr;
  assign bus.rsp_err   = r_rsp_err;

  assign w_accept    = bus.req_valid & bus.req_ready & ~bus.flush;
  // With LATENCY==1 the response is captured on the acceptance edge, before
  // the address register holds the request.
  assign w_rd_addr   = (r_state == IDLE) ? bus.req_addr : r_addr;
  assign w_rd_idx    = w_rd_addr[DEPTH_LOG2:1];
  assign w_ld_idx    = bus.ld_addr[DEPTH_LOG2:1];
  assign w_unused_ld = ^bus.ld_addr;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_next       = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (bus.flush) begin
          w_next = IDLE;
        end else if (r_cnt == 4'd1) begin
          w_next       = RESP;
          w_enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (bus.flush || bus.rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 4'd0;
      r_addr      <= 16'h0000;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 16'h0000;
      r_rsp_addr  <= 16'h0000;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept)              r_cnt <= 4'(LATENCY - 1);
      else if (r_state == BUSY)  r_cnt <= r_cnt - 4'd1;
      if (w_accept) r_addr <= bus.req_addr;

      // Array read here sees the pre-edge contents, so a same-edge preload
      // of this word leaves the old instruction in the response.
      if (w_enter_resp) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= w_rd_addr[0] ? 16'h0000 : mem[w_rd_idx];
        r_rsp_addr  <= w_rd_addr;
        r_rsp_err   <= w_rd_addr[0];
      end else if (w_next == IDLE) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.ld_en) mem[w_ld_idx] <= bus.ld_data;
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: LATENCY=4 main instance plus a small
// DEPTH_LOG2=4 / LATENCY=1 instance for wrap and single-cycle latency.
module tb_imem_responder;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_responder_if bus0();
  imem_responder_if bus1();

  imem_responder #(.DEPTH_LOG2(15), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  imem_responder #(.DEPTH_LOG2(4), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic        err;
  } rsp_t;

  rsp_t        sb[$];
  logic [15:0] mdl [int];
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load0(input logic [15:0] a, input logic [15:0] d);
    bus0.ld_en = 1'b1; bus0.ld_addr = a; bus0.ld_data = d;
    tick();
    bus0.ld_en = 1'b0;
    mdl[int'(a[15:1])] = d;
  endtask

  task automatic watch_quiet(input string name, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (bus0.rsp_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL %s: rsp_valid seen=%b expected 0", name, seen);
    end
  endtask

  // Issue one request on bus0, hold rsp_ready low for 'hold' valid cycles.
  task automatic issue(input logic [15:0] a, input int hold);
    rsp_t exp, got;
    int lat;
    logic [15:0] snap;
    exp.addr = a;
    exp.err  = a[0];
    exp.data = a[0] ? 16'h0000 :
               (mdl.exists(int'(a[15:1])) ? mdl[int'(a[15:1])] : 16'h0000);
    sb.push_back(exp);
    checks++;
    if (bus0.req_ready !== 1'b1) begin
      errors++; $display("FAIL idle_req_ready: got %b expected 1", bus0.req_ready);
    end
    bus0.req_valid = 1'b1; bus0.req_addr = a; bus0.rsp_ready = (hold == 0);
    tick();
    bus0.req_valid = 1'b0;
    lat = 1;
    while (bus0.rsp_valid !== 1'b1 && lat < 40) begin
      checks++;
      if (bus0.req_ready !== 1'b0) begin
        errors++; $display("FAIL busy_req_ready: got %b expected 0", bus0.req_ready);
      end
      tick(); lat++;
    end
    checks++;
    if (lat != LAT) begin
      errors++; $display("FAIL latency: got %0d expected %0d", lat, LAT);
    end
    if (bus0.rsp_valid !== 1'b1) begin
      void'(sb.pop_front());
      return;
    end
    snap = bus0.rsp_data;
    for (int i = 0; i < hold; i++) begin
      tick();
      checks++;
      if (bus0.rsp_valid !== 1'b1 || bus0.rsp_data !== snap || bus0.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold: valid=%b data=%h ready=%b expected 1/%h/0",
                 bus0.rsp_valid, bus0.rsp_data, bus0.req_ready, snap);
      end
    end
    bus0.rsp_ready = 1'b1;
    got = {bus0.rsp_addr, bus0.rsp_data, bus0.rsp_err};
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL response: got %h expected %h (addr,data,err)", got, exp);
    end
    tick();
    bus0.rsp_ready = 1'b0;
    checks++;
    if (bus0.rsp_valid !== 1'b0 || bus0.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_handshake: valid=%b req_ready=%b expected 0/1",
               bus0.rsp_valid, bus0.req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus0.req_valid = 0; bus0.req_addr = 0; bus0.rsp_ready = 0; bus0.flush = 0;
    bus0.ld_en = 0; bus0.ld_addr = 0; bus0.ld_data = 0;
    bus1.req_valid = 0; bus1.req_addr = 0; bus1.rsp_ready = 0; bus1.flush = 0;
    bus1.ld_en = 0; bus1.ld_addr = 0; bus1.ld_data = 0;
    repeat (3) tick();
    checks++;
    if ({bus0.req_ready, bus0.rsp_valid, bus0.rsp_data, bus0.rsp_addr, bus0.rsp_err} !== 35'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b data=%h addr=%h err=%b expected all 0",
               bus0.req_ready, bus0.rsp_valid, bus0.rsp_data, bus0.rsp_addr, bus0.rsp_err);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus0.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b expected 1", bus0.req_ready);
    end
    tick();
  endtask

  task automatic test_basic();
    load0(16'h0004, 16'hA123);
    issue(16'h0004, 0);
  endtask

  task automatic test_backpressure();
    issue(16'h0004, 3);
  endtask

  task automatic test_misaligned();
    load0(16'h0012, 16'hDEAD);
    issue(16'h0013, 0);
  endtask

  task automatic test_flush_busy();
    load0(16'h0006, 16'hBEEF);
    load0(16'h0008, 16'h7777);
    bus0.req_valid = 1'b1; bus0.req_addr = 16'h0008; bus0.rsp_ready = 1'b1;
    tick();
    bus0.req_valid = 1'b0;
    tick();
    bus0.flush = 1'b1;
    tick();
    bus0.flush = 1'b0;
    checks++;
    if (bus0.rsp_valid !== 1'b0 || bus0.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_busy: valid=%b req_ready=%b expected 0/1",
               bus0.rsp_valid, bus0.req_ready);
    end
    bus0.rsp_ready = 1'b0;
    watch_quiet("flush_busy_quiet", LAT + 3);
    issue(16'h0006, 0);
  endtask

  task automatic test_flush_idle();
    bus0.req_valid = 1'b1; bus0.req_addr = 16'h0006; bus0.flush = 1'b1;
    tick();
    bus0.req_valid = 1'b0; bus0.flush = 1'b0;
    checks++;
    if (bus0.req_ready !== 1'b1) begin
      errors++; $display("FAIL flush_idle_block: req_ready=%b expected 1", bus0.req_ready);
    end
    watch_quiet("flush_idle_quiet", LAT + 3);
  endtask

  task automatic test_preload_race();
    load0(16'h0020, 16'h2222);
    bus0.req_valid = 1'b1; bus0.req_addr = 16'h0020; bus0.rsp_ready = 1'b0;
    tick();
    bus0.req_valid = 1'b0;
    for (int i = 0; i < LAT - 2; i++) tick();
    load0(16'h0020, 16'h1111);
    checks++;
    if (bus0.rsp_valid !== 1'b1 || bus0.rsp_data !== 16'h2222) begin
      errors++;
      $display("FAIL race_old_word: valid=%b data=%h expected 1/2222",
               bus0.rsp_valid, bus0.rsp_data);
    end
    load0(16'h0020, 16'h3333);
    checks++;
    if (bus0.rsp_valid !== 1'b1 || bus0.rsp_data !== 16'h2222) begin
      errors++;
      $display("FAIL resp_write_hold: valid=%b data=%h expected 1/2222",
               bus0.rsp_valid, bus0.rsp_data);
    end
    bus0.rsp_ready = 1'b1;
    tick();
    bus0.rsp_ready = 1'b0;
    issue(16'h0020, 0);
  endtask

  task automatic test_back_to_back();
    issue(16'h0004, 0);
    issue(16'h0006, 1);
    issue(16'h0008, 0);
  endtask

  task automatic test_wrap_lat1();
    logic [15:0] addrs [2];
    addrs[0] = 16'h003E;
    addrs[1] = 16'hFFFE;
    bus1.ld_en = 1'b1; bus1.ld_addr = 16'h001E; bus1.ld_data = 16'h5A5A;
    tick();
    bus1.ld_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus1.req_valid = 1'b1; bus1.req_addr = addrs[k]; bus1.rsp_ready = 1'b0;
      tick();
      bus1.req_valid = 1'b0;
      checks++;
      if (bus1.rsp_valid !== 1'b1 || bus1.rsp_data !== 16'h5A5A ||
          bus1.rsp_addr !== addrs[k] || bus1.rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL wrap_lat1: valid=%b data=%h addr=%h err=%b expected 1/5a5a/%h/0",
                 bus1.rsp_valid, bus1.rsp_data, bus1.rsp_addr, bus1.rsp_err, addrs[k]);
      end
      bus1.rsp_ready = 1'b1;
      tick();
      bus1.rsp_ready = 1'b0;
      checks++;
      if (bus1.rsp_valid !== 1'b0 || bus1.req_ready !== 1'b1) begin
        errors++;
        $display("FAIL wrap_release: valid=%b req_ready=%b expected 0/1",
                 bus1.rsp_valid, bus1.req_ready);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus0.req_valid = 1'b1; bus0.req_addr = 16'h0004; bus0.rsp_ready = 1'b1;
    tick();
    bus0.req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (bus0.rsp_valid !== 1'b0 || bus0.rsp_data !== 16'h0000 ||
        bus0.rsp_addr !== 16'h0000 || bus0.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b data=%h addr=%h ready=%b expected 0/0000/0000/0",
               bus0.rsp_valid, bus0.rsp_data, bus0.rsp_addr, bus0.req_ready);
    end
    tick();
    checks++;
    if (bus0.req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_hold_ready: got %b expected 0", bus0.req_ready);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus0.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_release: got %b expected 1", bus0.req_ready);
    end
    bus0.rsp_ready = 1'b0;
    watch_quiet("reset_mid_quiet", LAT + 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_misaligned();
    test_flush_busy();
    test_flush_idle();
    test_preload_race();
    test_back_to_back();
    test_wrap_lat1();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
